// File: rtl/fp_operand_unpacker.sv
// -----------------------------------------------------------------------------
// fp_operand_unpacker
//
// Front-end stage of the floating-point adder datapath. Accepts a pair of
// packed IEEE-754 operands over a valid/ready handshake and unpacks each one
// into extended form {sign, exp, hidden, mantissa, guard}. The pair is
// classified (zero/normal exponents, Inf/NaN) and can be ordered so that the
// larger magnitude always appears on na. The result is registered behind a
// 2-entry skid buffer, so in_ready never depends combinationally on out_ready.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-high reset
//   in_valid  in   operand pair valid
//   in_ready  out  unpacker can accept (decoded from the state register only)
//   num_a     in   packed operand A, W = 1+EXP_W+MAN_W bits
//   num_b     in   packed operand B, W bits
//   out_valid out  result valid
//   out_ready in   downstream accepts
//   na        out  unpacked larger (or first) operand, X = 2+EXP_W+MAN_W+GRD_W
//   nb        out  unpacked other operand, X bits
//   e_data    out  00 both exp==0, 01 both exp!=0, 10 exactly one exp==0
//   swapped   out  na holds num_b
//   inf_flag  out  an Inf operand is present and the result is not NaN
//   nan_flag  out  a NaN operand, or Inf + Inf with opposite signs
// -----------------------------------------------------------------------------
module fp_operand_unpacker #(
    parameter int EXP_W   = 8,
    parameter int MAN_W   = 23,
    parameter int GRD_W   = 4,
    parameter int SWAP_EN = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [EXP_W+MAN_W:0]             num_a,
    input  logic [EXP_W+MAN_W:0]             num_b,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [1+EXP_W+MAN_W+GRD_W:0]     na,
    output logic [1+EXP_W+MAN_W+GRD_W:0]     nb,
    output logic [1:0]                       e_data,
    output logic                             swapped,
    output logic                             inf_flag,
    output logic                             nan_flag
);

    localparam int W = 1 + EXP_W + MAN_W;
    localparam int X = 2 + EXP_W + MAN_W + GRD_W;

    // One buffered result: both unpacked operands plus classification.
    typedef struct packed {
        logic [X-1:0] na;
        logic [X-1:0] nb;
        logic [1:0]   e_data;
        logic         swapped;
        logic         inf_flag;
        logic         nan_flag;
    } entry_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_TWO   = 2'b10
    } state_t;

    // ------------------------------------------------------------------
    // Field helpers
    // ------------------------------------------------------------------
    function automatic logic [EXP_W-1:0] exp_of(input logic [W-1:0] num);
        return num[W-2:MAN_W];
    endfunction

    function automatic logic [MAN_W-1:0] man_of(input logic [W-1:0] num);
        return num[MAN_W-1:0];
    endfunction

    // Exponent all-ones marks Inf or NaN.
    function automatic logic is_special(input logic [W-1:0] num);
        return &exp_of(num);
    endfunction

    function automatic logic is_nan(input logic [W-1:0] num);
        return is_special(num) && (man_of(num) != {MAN_W{1'b0}});
    endfunction

    function automatic logic is_inf(input logic [W-1:0] num);
        return is_special(num) && (man_of(num) == {MAN_W{1'b0}});
    endfunction

    // Denormals and zeros keep their raw zero exponent and get hidden = 0.
    function automatic logic [X-1:0] unpack(input logic [W-1:0] num);
        return {num[W-1], exp_of(num), |exp_of(num), man_of(num), {GRD_W{1'b0}}};
    endfunction

    // ------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------
    state_t       state_r;
    state_t       state_s;
    entry_t       main_r;
    entry_t       skid_r;
    entry_t       new_entry_s;
    logic         in_xfer_s;
    logic         out_xfer_s;
    logic         load_main_new_s;
    logic         load_main_skid_s;
    logic         load_skid_s;

    logic         a_nan_s;
    logic         b_nan_s;
    logic         a_inf_s;
    logic         b_inf_s;
    logic         a_exp_nz_s;
    logic         b_exp_nz_s;
    logic         b_bigger_s;
    logic         do_swap_s;

    // Ready/valid come straight from the state register: no combinational
    // path from out_ready to in_ready.
    assign in_ready   = (state_r != ST_TWO);
    assign out_valid  = (state_r != ST_EMPTY);
    assign in_xfer_s  = in_valid && in_ready;
    assign out_xfer_s = out_valid && out_ready;

    // Classify the incoming pair and build the entry that would be stored.
    always_comb begin
        new_entry_s = '0;
        a_nan_s     = is_nan(num_a);
        b_nan_s     = is_nan(num_b);
        a_inf_s     = is_inf(num_a);
        b_inf_s     = is_inf(num_b);
        a_exp_nz_s  = |exp_of(num_a);
        b_exp_nz_s  = |exp_of(num_b);
        // Magnitude is the unsigned {exp, man}; ties leave the order alone.
        b_bigger_s  = (num_b[W-2:0] > num_a[W-2:0]);
        do_swap_s   = (SWAP_EN != 0) && b_bigger_s;

        if (do_swap_s) begin
            new_entry_s.na = unpack(num_b);
            new_entry_s.nb = unpack(num_a);
        end else begin
            new_entry_s.na = unpack(num_a);
            new_entry_s.nb = unpack(num_b);
        end
        new_entry_s.swapped = do_swap_s;

        // Inf - Inf (opposite signs) has no defined result, so it is NaN.
        new_entry_s.nan_flag = a_nan_s || b_nan_s ||
                               (a_inf_s && b_inf_s && (num_a[W-1] != num_b[W-1]));
        new_entry_s.inf_flag = (a_inf_s || b_inf_s) && !new_entry_s.nan_flag;

        case ({a_exp_nz_s, b_exp_nz_s})
            2'b00:   new_entry_s.e_data = 2'b00;
            2'b11:   new_entry_s.e_data = 2'b01;
            2'b01:   new_entry_s.e_data = 2'b10;
            2'b10:   new_entry_s.e_data = 2'b10;
            default: new_entry_s.e_data = 2'b00;
        endcase
    end

    // Buffer occupancy register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and buffer load controls.
    always_comb begin
        state_s          = state_r;
        load_main_new_s  = 1'b0;
        load_main_skid_s = 1'b0;
        load_skid_s      = 1'b0;
        case (state_r)
            ST_EMPTY: begin
                if (in_xfer_s) begin
                    state_s         = ST_ONE;
                    load_main_new_s = 1'b1;
                end else begin
                    state_s = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (in_xfer_s && out_xfer_s) begin
                    state_s         = ST_ONE;
                    load_main_new_s = 1'b1;
                end else if (in_xfer_s) begin
                    // Downstream stalled: park the new pair in the skid slot.
                    state_s     = ST_TWO;
                    load_skid_s = 1'b1;
                end else if (out_xfer_s) begin
                    state_s = ST_EMPTY;
                end else begin
                    state_s = ST_ONE;
                end
            end
            ST_TWO: begin
                // in_ready is low here, so only the output side can move.
                if (out_xfer_s) begin
                    state_s          = ST_ONE;
                    load_main_skid_s = 1'b1;
                end else begin
                    state_s = ST_TWO;
                end
            end
            default: begin
                state_s = ST_EMPTY;
            end
        endcase
    end

    // Main (output-facing) register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_r <= '0;
        end else if (load_main_new_s) begin
            main_r <= new_entry_s;
        end else if (load_main_skid_s) begin
            main_r <= skid_r;
        end else begin
            main_r <= main_r;
        end
    end

    // Skid register, filled only when the main entry is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_r <= '0;
        end else if (load_skid_s) begin
            skid_r <= new_entry_s;
        end else begin
            skid_r <= skid_r;
        end
    end

    assign na       = main_r.na;
    assign nb       = main_r.nb;
    assign e_data   = main_r.e_data;
    assign swapped  = main_r.swapped;
    assign inf_flag = main_r.inf_flag;
    assign nan_flag = main_r.nan_flag;

endmodule

// File: tb/tb_fp_operand_unpacker.sv
// -----------------------------------------------------------------------------
// tb_fp_operand_unpacker
//
// Directed bench for fp_operand_unpacker with default widths (X = 37) and
// magnitude ordering enabled. Inputs change 1 time unit after a rising edge;
// outputs are checked at that same point, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_fp_operand_unpacker;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] num_a;
    logic [31:0] num_b;
    logic        out_valid;
    logic        out_ready;
    logic [36:0] na;
    logic [36:0] nb;
    logic [1:0]  e_data;
    logic        swapped;
    logic        inf_flag;
    logic        nan_flag;

    int n_checks;
    int n_fail;

    fp_operand_unpacker #(
        .EXP_W   (8),
        .MAN_W   (23),
        .GRD_W   (4),
        .SWAP_EN (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .num_a     (num_a),
        .num_b     (num_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .na        (na),
        .nb        (nb),
        .e_data    (e_data),
        .swapped   (swapped),
        .inf_flag  (inf_flag),
        .nan_flag  (nan_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b);
        in_valid = v;
        num_a    = a;
        num_b    = b;
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        num_a     = 32'h0;
        num_b     = 32'h0;
        out_ready = 1'b0;

        // Reset state
        #12;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready",  in_ready,  1'b1);
        check("rst_na",        na,        37'h0);
        check("rst_nb",        nb,        37'h0);
        check("rst_flags",     {e_data, swapped, inf_flag, nan_flag}, 5'b0);
        step();
        rst = 1'b0;

        // Ordering: 1.0 vs 2.0 -> swap
        out_ready = 1'b1;
        drive(1'b1, 32'h3F800000, 32'h40000000);
        step();
        check("ord_out_valid", out_valid, 1'b1);
        check("ord_na",        na,        37'h0808000000);
        check("ord_nb",        nb,        37'h07F8000000);
        check("ord_swapped",   swapped,   1'b1);
        check("ord_e_data",    e_data,    2'b01);
        check("ord_flags",     {inf_flag, nan_flag}, 2'b00);

        // Denormal vs 1.0
        drive(1'b1, 32'h00400000, 32'h3F800000);
        step();
        check("den_e_data",  e_data,  2'b10);
        check("den_swapped", swapped, 1'b1);
        check("den_na",      na,      37'h07F8000000);
        check("den_nb",      nb,      37'h0004000000);

        // +Inf + -Inf -> NaN
        drive(1'b1, 32'h7F800000, 32'hFF800000);
        step();
        check("infinf_nan",     nan_flag, 1'b1);
        check("infinf_inf",     inf_flag, 1'b0);
        check("infinf_swapped", swapped,  1'b0);

        // +Inf + 1.0 -> Inf
        drive(1'b1, 32'h7F800000, 32'h3F800000);
        step();
        check("inf_inf",    inf_flag, 1'b1);
        check("inf_nan",    nan_flag, 1'b0);
        check("inf_e_data", e_data,   2'b01);
        check("inf_na",     na,       37'h0FF8000000);

        // qNaN + 1.0
        drive(1'b1, 32'h7FC00000, 32'h3F800000);
        step();
        check("nan_nan", nan_flag, 1'b1);
        check("nan_inf", inf_flag, 1'b0);

        // -0 vs +0: equal magnitude, no swap
        drive(1'b1, 32'h80000000, 32'h00000000);
        step();
        check("zero_e_data",  e_data,  2'b00);
        check("zero_swapped", swapped, 1'b0);
        check("zero_na",      na,      37'h1000000000);
        check("zero_nb",      nb,      37'h0);

        // Drain
        drive(1'b0, 32'h0, 32'h0);
        step();
        check("drain_out_valid", out_valid, 1'b0);

        // Backpressure: three pairs with out_ready low
        out_ready = 1'b0;
        drive(1'b1, 32'h40400000, 32'h3F800000);   // P1
        step();
        check("bp1_out_valid", out_valid, 1'b1);
        check("bp1_in_ready",  in_ready,  1'b1);
        drive(1'b1, 32'h00000000, 32'h40000000);   // P2
        step();
        check("bp2_in_ready", in_ready, 1'b0);
        check("bp2_na_hold",  na,       37'h080C000000);
        drive(1'b1, 32'hBF800000, 32'h00000000);   // P3, held off
        step();
        check("bp3_in_ready", in_ready, 1'b0);
        check("bp3_na_hold",  na,       37'h080C000000);
        check("bp3_nb_hold",  nb,       37'h07F8000000);
        out_ready = 1'b1;
        step();
        check("bp_p2_na",      na,       37'h0808000000);
        check("bp_p2_nb",      nb,       37'h0);
        check("bp_p2_swapped", swapped,  1'b1);
        check("bp_p2_ready",   in_ready, 1'b1);
        step();
        drive(1'b0, 32'h0, 32'h0);
        check("bp_p3_na",      na,        37'h17F8000000);
        check("bp_p3_nb",      nb,        37'h0);
        check("bp_p3_e_data",  e_data,    2'b10);
        check("bp_p3_valid",   out_valid, 1'b1);
        step();
        check("bp_empty",      out_valid, 1'b0);

        // Reset while the buffer holds two entries
        out_ready = 1'b0;
        drive(1'b1, 32'h3F800000, 32'h00000000);
        step();
        drive(1'b1, 32'h40000000, 32'h00000000);
        step();
        drive(1'b0, 32'h0, 32'h0);
        check("mid_two_ready", in_ready, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", out_valid, 1'b0);
        check("mid_rst_ready", in_ready,  1'b1);
        check("mid_rst_na",    na,        37'h0);
        check("mid_rst_nb",    nb,        37'h0);
        check("mid_rst_flags", {e_data, swapped, inf_flag, nan_flag}, 5'b0);
        step();
        rst       = 1'b0;
        out_ready = 1'b1;
        check("post_rst_valid", out_valid, 1'b0);
        drive(1'b1, 32'h3F800000, 32'h40000000);
        step();
        drive(1'b0, 32'h0, 32'h0);
        check("post_rst_valid1", out_valid, 1'b1);
        check("post_rst_na",     na,        37'h0808000000);
        check("post_rst_nb",     nb,        37'h07F8000000);
        step();
        check("post_rst_empty",  out_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
